alien_shot_scheduler: RTL and testbench

Frame-paced scheduler that decides when an alien fires and which missile slot carries the shot. It arbitrates round-robin among per-column shot requests from the alien formation and allocates the lowest-index idle missile slot. It issues a one-cycle launch pulse plus launch X coordinate to that slot, then enforces a frame-counted cooldown. It sits between the alien-grid logic and a bank of missile objects, each of which reports its own active flag.

---
 rtl/alien_shot_scheduler.sv | 170 +++++++++++++++++
 tb/tb_alien_shot_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alien_shot_scheduler.sv
// Frame-paced alien fire scheduler: round-robin column arbitration, lowest-free
// missile slot allocation, one-cycle launch pulse, ack timeout and frame cooldown.
module alien_shot_scheduler #(
    parameter int unsigned N_REQ           = 8,
    parameter int unsigned N_SLOTS         = 4,
    parameter int unsigned COOLDOWN_FRAMES = 20,
    parameter int unsigned COL_BASE_X      = 32,
    parameter int unsigned COL_PITCH       = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic [N_REQ-1:0]   reqVec,
    input  logic [N_SLOTS-1:0] slotActive,
    output logic [N_SLOTS-1:0] launch,
    output logic [10:0]        launchX,
    output logic [2:0]         grantIdx,
    output logic               cooldownActive,
    output logic               launchFail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_ACK,
        S_COOLDOWN
    } state_t;

    state_t             state_q, state_d;
    logic [N_SLOTS-1:0] launch_q, launch_d;
    logic [10:0]        launchX_q, launchX_d;
    logic [2:0]         grantIdx_q, grantIdx_d;
    logic [2:0]         lastGrant_q, lastGrant_d;
    logic [1:0]         slot_q, slot_d;
    logic [1:0]         ack_q, ack_d;
    logic [7:0]         cool_q, cool_d;
    logic               cooldownActive_q, cooldownActive_d;
    logic               launchFail_q, launchFail_d;

    logic               can_fire;
    logic               hi_found;
    logic [2:0]         hi_col, lo_col, pick_col;
    logic [1:0]         pick_slot;
    logic               ack_seen;
    logic [N_SLOTS-1:0] slot_onehot;

    assign can_fire = enable && (|reqVec) && !(&slotActive);

    // Round-robin: lowest requester above lastGrant, else wrap to lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_col   = '0;
        lo_col   = '0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (reqVec[i-1]) begin
                lo_col = 3'(i - 1);
                if (3'(i - 1) > lastGrant_q) begin
                    hi_found = 1'b1;
                    hi_col   = 3'(i - 1);
                end
            end
        end
        pick_col = hi_found ? hi_col : lo_col;
    end

    always_comb begin
        pick_slot   = '0;
        ack_seen    = 1'b0;
        slot_onehot = '0;
        for (int unsigned j = N_SLOTS; j > 0; j--) begin
            if (!slotActive[j-1]) pick_slot = 2'(j - 1);
        end
        for (int unsigned j = 0; j < N_SLOTS; j++) begin
            if (2'(j) == slot_q) begin
                ack_seen       = slotActive[j];
                slot_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        launch_d         = '0;
        launchX_d        = launchX_q;
        grantIdx_d       = grantIdx_q;
        lastGrant_d      = lastGrant_q;
        slot_d           = slot_q;
        ack_d            = ack_q;
        cool_d           = cool_q;
        cooldownActive_d = cooldownActive_q;
        launchFail_d     = launchFail_q;
        case (state_q)
            S_IDLE: begin
                if (startOfFrame && can_fire) state_d = S_ARB;
            end
            S_ARB: begin
                if (can_fire) begin
                    slot_d      = pick_slot;
                    grantIdx_d  = pick_col;
                    lastGrant_d = pick_col;
                    launchX_d   = 11'(COL_BASE_X) + 11'(pick_col) * 11'(COL_PITCH);
                    state_d     = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                launch_d = slot_onehot;
                ack_d    = '0;
                state_d  = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack_seen) begin
                    cool_d           = 8'(COOLDOWN_FRAMES);
                    cooldownActive_d = 1'b1;
                    state_d          = S_COOLDOWN;
                end else if (ack_q == 2'd3) begin
                    launchFail_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    ack_d = ack_q + 2'd1;
                end
            end
            S_COOLDOWN: begin
                if (cool_q == '0) begin
                    cooldownActive_d = 1'b0;
                    state_d          = S_IDLE;
                end else if (startOfFrame) begin
                    cool_d = cool_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= S_IDLE;
            launch_q         <= '0;
            launchX_q        <= '0;
            grantIdx_q       <= '0;
            lastGrant_q      <= 3'(N_REQ - 1);
            slot_q           <= '0;
            ack_q            <= '0;
            cool_q           <= '0;
            cooldownActive_q <= 1'b0;
            launchFail_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            launch_q         <= launch_d;
            launchX_q        <= launchX_d;
            grantIdx_q       <= grantIdx_d;
            lastGrant_q      <= lastGrant_d;
            slot_q           <= slot_d;
            ack_q            <= ack_d;
            cool_q           <= cool_d;
            cooldownActive_q <= cooldownActive_d;
            launchFail_q     <= launchFail_d;
        end
    end

    assign launch         = launch_q;
    assign launchX        = launchX_q;
    assign grantIdx       = grantIdx_q;
    assign cooldownActive = cooldownActive_q;
    assign launchFail     = launchFail_q;

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Directed bench for alien_shot_scheduler; inputs driven and outputs sampled on negedge.
module tb_alien_shot_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        enable;
    logic [7:0]  reqVec;
    logic [3:0]  slotActive;
    logic [3:0]  launch;
    logic [10:0] launchX;
    logic [2:0]  grantIdx;
    logic        cooldownActive;
    logic        launchFail;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    alien_shot_scheduler #(
        .N_REQ(8),
        .N_SLOTS(4),
        .COOLDOWN_FRAMES(2),
        .COL_BASE_X(32),
        .COL_PITCH(64)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .enable(enable),
        .reqVec(reqVec),
        .slotActive(slotActive),
        .launch(launch),
        .launchX(launchX),
        .grantIdx(grantIdx),
        .cooldownActive(cooldownActive),
        .launchFail(launchFail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    // Frame pulse, then check the launch appears exactly in the cycle after edge k+2.
    task automatic fire_and_check(input string tag, input logic [3:0] exp_l,
                                  input int unsigned exp_x, input int unsigned exp_g);
        sof_pulse();
        tick(1);
        check({tag, "_early"}, 32'(launch), 32'd0);
        tick(1);
        check({tag, "_launch"}, 32'(launch), 32'(exp_l));
        check({tag, "_x"}, 32'(launchX), exp_x);
        check({tag, "_grant"}, 32'(grantIdx), exp_g);
    endtask

    task automatic cool_out();
        tick(2);
        sof_pulse();
        tick(2);
        sof_pulse();
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; enable = 1'b0; reqVec = '0; slotActive = '0;
        tick(2);
        check("rst_launch", 32'(launch), 32'd0);
        check("rst_x", 32'(launchX), 32'd0);
        check("rst_grant", 32'(grantIdx), 32'd0);
        check("rst_cool", 32'(cooldownActive), 32'd0);
        check("rst_fail", 32'(launchFail), 32'd0);
        resetN = 1'b1;
        tick(2);

        // First launch: column 0, slot 0, one-cycle pulse, then cooldown.
        enable = 1'b1; reqVec = 8'b0000_0101;
        fire_and_check("first", 4'b0001, 32, 0);
        slotActive = 4'b0001;
        tick(1);
        check("pulse_one_cycle", 32'(launch), 32'd0);
        check("cool_enter", 32'(cooldownActive), 32'd1);
        tick(2);
        sof_pulse();
        check("cool_frame1", 32'(cooldownActive), 32'd1);
        tick(3);
        sof_pulse();
        check("cool_frame2", 32'(cooldownActive), 32'd1);
        tick(1);
        check("cool_exit", 32'(cooldownActive), 32'd0);
        check("cool_no_launch", 32'(launch), 32'd0);
        fire_and_check("second", 4'b0010, 160, 2);
        slotActive = 4'b0011;
        cool_out();

        // All slots busy: no launch for 5 frames; free slot 2 then launch.
        slotActive = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sof_pulse();
            tick(2);
            check("busy_no_launch", 32'(launch), 32'd0);
            tick(2);
        end
        slotActive = 4'b1011;
        fire_and_check("slot2", 4'b0100, 32, 0);
        slotActive = 4'b1111;
        cool_out();

        // No acknowledge: launchFail four cycles after launch, no cooldown.
        slotActive = 4'b0000;
        fire_and_check("noack", 4'b0001, 160, 2);
        tick(3);
        check("fail_not_yet", 32'(launchFail), 32'd0);
        tick(1);
        check("fail_set", 32'(launchFail), 32'd1);
        check("fail_no_cool", 32'(cooldownActive), 32'd0);
        fire_and_check("after_fail", 4'b0001, 32, 0);
        check("fail_sticky", 32'(launchFail), 32'd1);
        slotActive = 4'b0001;
        cool_out();
        slotActive = 4'b0000;

        // ARB abort via reqVec and via enable; pointer must not advance.
        sof_pulse();
        reqVec = 8'b0000_0000;
        tick(2);
        check("abort_req", 32'(launch), 32'd0);
        reqVec = 8'b0000_0101;
        check("abort_grant_held", 32'(grantIdx), 32'd0);
        tick(1);
        sof_pulse();
        enable = 1'b0;
        tick(2);
        check("abort_en", 32'(launch), 32'd0);
        enable = 1'b1;
        tick(1);
        fire_and_check("post_abort", 4'b0001, 160, 2);
        slotActive = 4'b0001;
        tick(1);
        check("cool_before_rst", 32'(cooldownActive), 32'd1);

        // Asynchronous reset during cooldown.
        resetN = 1'b0;
        #1;
        check("arst_launch", 32'(launch), 32'd0);
        check("arst_x", 32'(launchX), 32'd0);
        check("arst_grant", 32'(grantIdx), 32'd0);
        check("arst_cool", 32'(cooldownActive), 32'd0);
        check("arst_fail", 32'(launchFail), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        slotActive = 4'b0000;
        reqVec = 8'hFF;
        tick(1);

        // Full round-robin rotation: 0..7 then back to 0.
        for (int i = 0; i < 9; i++) begin
            fire_and_check("rr", 4'b0001, 32 + 64 * (i % 8), i % 8);
            slotActive = 4'b0001;
            cool_out();
            slotActive = 4'b0000;
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
